// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// ifu_prefetch : in-order instruction prefetch buffer with redirect squashing
// Rev 1.0
// ============================================================================

module ifu_prefetch #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];

  logic req_fire;
  logic rsp_drop;
  logic rsp_fill;
  logic consume;

  // Requests are held off during reset so nothing leaks out before the first edge.
  assign imem_req_valid = rst && !redirect && (count_q < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign inst_valid = (count_q != '0) && filled_q[head_q];
  assign inst       = inst_q[head_q];
  assign inst_pc    = pc_q[head_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);
  assign consume  = inst_valid && inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    if (redirect) begin
      // Every issued-but-unanswered request becomes stale; a response landing
      // this cycle answers one of them, whether it was headed for a drop or a fill.
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      pend_d     = '0;
      filled_d   = '0;
      drop_d     = drop_q + pend_q - CW'(rsp_drop || rsp_fill);
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (req_fire) begin
        tail_d     = tail_q + PW'(1);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (rsp_fill) begin
        fill_d           = fill_q + PW'(1);
        filled_d[fill_q] = 1'b1;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (consume) begin
        head_d           = head_q + PW'(1);
        filled_d[head_q] = 1'b0;
      end
      count_d = count_q + CW'(req_fire) - CW'(consume);
      pend_d  = pend_q + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  // Payload storage needs no reset: the filled bits and count gate its use.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_q[tail_q] <= fetch_pc_q;
    end
    if (rsp_fill && !redirect) begin
      inst_q[fill_q] <= imem_rsp_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// tb_ifu_prefetch : randomized and directed checks of ifu_prefetch against a
// queue-based reference model. Rev 1.0
// ============================================================================

module tb_ifu_prefetch;

  localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect;
  logic [63:0] redirect_pc;

  logic        w_rst;
  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [63:0] w_inst_pc;

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(RST_PC)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  ifu_prefetch #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
    .clk           (clk),
    .rst           (w_rst),
    .imem_req_valid(w_req_valid),
    .imem_req_ready(1'b1),
    .imem_req_addr (w_req_addr),
    .imem_rsp_valid(1'b0),
    .imem_rsp_data (32'h0),
    .inst_valid    (w_inst_valid),
    .inst_ready    (1'b0),
    .inst          (w_inst),
    .inst_pc       (w_inst_pc),
    .redirect      (1'b0),
    .redirect_pc   (64'h0)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int rsp_pct    = 100;

  typedef struct {
    logic [63:0] addr;
    int          cyc;
  } mreq_t;
  mreq_t mem_q[$];

  // Reference model: allocated slot PCs in order, and the filled prefix of them.
  logic [63:0] m_pc[$];
  logic [31:0] m_inst[$];
  logic [63:0] m_fetch;
  int          m_drop;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_mem();
    if (mem_q.size() > 0 && mem_q[0].cyc < cyc && int'($urandom_range(99)) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic reset_env();
    m_pc.delete();
    m_inst.delete();
    m_fetch        = RST_PC;
    m_drop         = 0;
    mem_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect       = 1'b0;
    redirect_pc    = 64'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    reset_env();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_mem();
  endtask

  // Advance model and memory by one clock using the inputs of the current cycle.
  task automatic tick();
    bit m_req_v;
    bit m_inst_v;
    int unfilled;
    m_req_v  = !redirect && (m_pc.size() < DEPTH);
    m_inst_v = m_inst.size() > 0;
    unfilled = m_pc.size() - m_inst.size();
    if (redirect) begin
      m_drop  = m_drop + unfilled - ((imem_rsp_valid && (m_drop > 0 || unfilled > 0)) ? 1 : 0);
      m_pc.delete();
      m_inst.delete();
      m_fetch = {redirect_pc[63:2], 2'b00};
    end else begin
      if (m_inst_v && inst_ready) begin
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (imem_rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else if (unfilled > 0) m_inst.push_back(imem_rsp_data);
      end
      if (m_req_v && imem_req_ready) begin
        m_pc.push_back(m_fetch);
        m_fetch = m_fetch + 64'd4;
      end
    end
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) mem_q.push_back('{addr: imem_req_addr, cyc: cyc});
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    rst            = 1'b0;
    reset_env();
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
    end
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_inst_valid: got %b expected 0", inst_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_mem();
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_req_valid: got %b expected 1", imem_req_valid);
    end
    vectors++;
    if (imem_req_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL first_req_addr: got %h expected %h", imem_req_addr, RST_PC);
    end
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_inst_valid: got %b expected 0", inst_valid);
    end
    tick();
  endtask

  task automatic test_streaming();
    logic [63:0] exp_pc;
    int          got;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    rsp_pct        = 100;
    apply_reset();
    exp_pc = RST_PC;
    got    = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        vectors++;
        if (inst_pc !== exp_pc) begin
          miscompares++;
          $display("FAIL stream_pc: got %h expected %h", inst_pc, exp_pc);
        end
        vectors++;
        if (inst !== inst_of(exp_pc)) begin
          miscompares++;
          $display("FAIL stream_inst: got %h expected %h", inst, inst_of(exp_pc));
        end
        exp_pc = exp_pc + 64'd4;
        got++;
      end
      tick();
    end
    vectors++;
    if (got !== 22) begin
      miscompares++;
      $display("FAIL stream_rate: got %0d delivered expected 22", got);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_req;
    logic [63:0] exp_pc;
    int          issued;
    int          used;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    rsp_pct        = 100;
    apply_reset();
    exp_req = RST_PC;
    exp_pc  = RST_PC;
    issued  = 0;
    used    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        vectors++;
        if (imem_req_addr !== exp_req) begin
          miscompares++;
          $display("FAIL bp_req_addr: got %h expected %h", imem_req_addr, exp_req);
        end
        exp_req = exp_req + 64'd4;
        issued++;
      end
      if (i == 9) begin
        vectors++;
        if (imem_req_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_full_req_valid: got %b expected 0", imem_req_valid);
        end
      end
      tick();
    end
    vectors++;
    if (issued !== DEPTH) begin
      miscompares++;
      $display("FAIL bp_issued: got %0d expected %0d", issued, DEPTH);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        vectors++;
        if (imem_req_addr !== exp_req) begin
          miscompares++;
          $display("FAIL bp_resume_addr: got %h expected %h", imem_req_addr, exp_req);
        end
        exp_req = exp_req + 64'd4;
      end
      if (inst_valid) begin
        vectors++;
        if (inst_pc !== exp_pc) begin
          miscompares++;
          $display("FAIL bp_inst_pc: got %h expected %h", inst_pc, exp_pc);
        end
        exp_pc = exp_pc + 64'd4;
        used++;
      end
      tick();
    end
    vectors++;
    if (used !== 14) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d delivered expected 14", used);
    end
  endtask

  // Wait (bounded) for the first delivered instruction and check it is the target.
  task automatic expect_first_at(input logic [63:0] target, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid && !seen) begin
        seen = 1'b1;
        vectors++;
        if (inst_pc !== target) begin
          miscompares++;
          $display("FAIL %s_first_pc: got %h expected %h", tag, inst_pc, target);
        end
        vectors++;
        if (inst !== inst_of(target)) begin
          miscompares++;
          $display("FAIL %s_first_inst: got %h expected %h", tag, inst, inst_of(target));
        end
      end
      tick();
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: got no instruction expected one within 20 cycles", tag);
    end
  endtask

  task automatic test_redirect();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    rsp_pct        = 0;
    apply_reset();
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    redirect    = 1'b1;
    redirect_pc = 64'h0000_0000_8000_1002;
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_req_blocked: got %b expected 0", imem_req_valid);
    end
    tick();
    redirect = 1'b0;
    rsp_pct  = 100;
    drive_mem();
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL redir_req_valid: got %b expected 1", imem_req_valid);
    end
    vectors++;
    if (imem_req_addr !== 64'h0000_0000_8000_1000) begin
      miscompares++;
      $display("FAIL redir_req_addr: got %h expected 0000000080001000", imem_req_addr);
    end
    tick();
    expect_first_at(64'h0000_0000_8000_1000, "redir");
  endtask

  task automatic test_redirect_collide();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    rsp_pct        = 100;
    apply_reset();
    @(negedge clk);
    tick();
    @(negedge clk);
    rsp_pct = 0;
    tick();
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    redirect    = 1'b1;
    redirect_pc = 64'h0000_0000_0000_2000;
    inst_ready  = 1'b1;
    rsp_pct     = 100;
    drive_mem();
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_head_valid: got %b expected 1", inst_valid);
    end
    vectors++;
    if (imem_rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_rsp_present: got %b expected 1", imem_rsp_valid);
    end
    tick();
    redirect = 1'b0;
    expect_first_at(64'h0000_0000_0000_2000, "collide");
  endtask

  task automatic test_async_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    rsp_pct        = 100;
    apply_reset();
    repeat (8) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_inst_valid: got %b expected 1", inst_valid);
    end
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_req_valid: got %b expected 0", imem_req_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_inst_valid: got %b expected 0", inst_valid);
    end
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_req_valid: got %b expected 0", imem_req_valid);
    end
    reset_env();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_mem();
    @(negedge clk);
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL async_restart: got valid %b addr %h expected valid 1 addr %h",
               imem_req_valid, imem_req_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_pc_wrap();
    w_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC) begin
      miscompares++;
      $display("FAIL wrap_first: got valid %b addr %h expected valid 1 addr %h",
               w_req_valid, w_req_addr, WRAP_PC);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (w_req_addr !== 64'h0) begin
      miscompares++;
      $display("FAIL wrap_second: got %h expected 0000000000000000", w_req_addr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (w_req_addr !== 64'h4) begin
      miscompares++;
      $display("FAIL wrap_third: got %h expected 0000000000000004", w_req_addr);
    end
    tick();
  endtask

  task automatic test_random();
    int          unfilled;
    bit          e_req_v;
    bit          e_inst_v;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    rsp_pct        = 60;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(2))
          0:       rsp_pct = 30;
          1:       rsp_pct = 60;
          default: rsp_pct = 100;
        endcase
      end
      imem_req_ready = ($urandom_range(3) != 0);
      inst_ready     = ($urandom_range(2) != 0);
      unfilled       = m_pc.size() - m_inst.size();
      if ($urandom_range(19) == 0 && (m_drop + unfilled) <= DEPTH) begin
        redirect    = 1'b1;
        redirect_pc = {$urandom, $urandom};
      end else begin
        redirect    = 1'b0;
      end
      @(negedge clk);
      e_req_v  = !redirect && (m_pc.size() < DEPTH);
      e_inst_v = m_inst.size() > 0;
      vectors++;
      if (imem_req_valid !== e_req_v) begin
        miscompares++;
        $display("FAIL rnd_req_valid @%0d: got %b expected %b", cyc, imem_req_valid, e_req_v);
      end
      vectors++;
      if (imem_req_addr !== m_fetch) begin
        miscompares++;
        $display("FAIL rnd_req_addr @%0d: got %h expected %h", cyc, imem_req_addr, m_fetch);
      end
      vectors++;
      if (inst_valid !== e_inst_v) begin
        miscompares++;
        $display("FAIL rnd_inst_valid @%0d: got %b expected %b", cyc, inst_valid, e_inst_v);
      end
      if (e_inst_v) begin
        vectors++;
        if (inst_pc !== m_pc[0]) begin
          miscompares++;
          $display("FAIL rnd_inst_pc @%0d: got %h expected %h", cyc, inst_pc, m_pc[0]);
        end
        vectors++;
        if (inst !== m_inst[0]) begin
          miscompares++;
          $display("FAIL rnd_inst @%0d: got %h expected %h", cyc, inst, m_inst[0]);
        end
      end
      tick();
    end
    redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b0;
    w_rst          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    reset_env();
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_async_reset();
    test_pc_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter XLEN, default 64: PC and address width.
REQ-002 Parameter DEPTH, default 4: prefetch slots; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 64'h0000_0000_8000_0000: first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  XLEN  fetch address; always 4-byte aligned.
REQ-009 imem_rsp_valid  input  1  instruction word returned, in request order.
REQ-010 imem_rsp_data  input  32  returned instruction.
REQ-011 inst_valid  output  1  head slot holds a filled instruction.
REQ-012 inst_ready  input  1  decode consumes head.
REQ-013 inst  output  32  head instruction.
REQ-014 inst_pc  output  XLEN  PC of head instruction.
REQ-015 redirect  input  1  branch/jump redirect, one-cycle pulse.
REQ-016 redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).

Function
REQ-017 Storage: DEPTH-entry circular buffer of {pc, inst, filled}, with head, fill and tail pointers plus occupancy count, all wrapping modulo DEPTH.
REQ-018 Request issue: imem_req_valid = !redirect && occupancy < DEPTH; imem_req_addr = fetch_pc.
REQ-019 A request handshake (valid && ready) allocates the tail slot with pc = fetch_pc and filled = 0, advances tail, and sets fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
REQ-020 Every allocated slot counts toward occupancy from issue until it is consumed, so no more than DEPTH requests are ever outstanding.
REQ-021 Response with drop_cnt = 0 and an unfilled allocated slot:
  - writes imem_rsp_data into the slot at fill;
  - sets its filled bit;
  - advances fill.
REQ-022 Response with drop_cnt > 0: data discarded, drop_cnt decremented, no slot written.
REQ-023 Response with drop_cnt = 0 and no unfilled slot: ignored; state unchanged.
REQ-024 Output: inst_valid = head slot allocated && filled; inst and inst_pc driven from the head slot; combinational from registers, no extra latency.
REQ-025 Consume: inst_valid && inst_ready frees the head slot and advances head.
REQ-026 The same cycle may carry issue, fill and consume together. Occupancy changes by (+1 issue) and (-1 consume) with no lost update; a slot may be filled and consumed in the same cycle only if it was filled in an earlier cycle.
REQ-027 Minimum latency: a response arriving in cycle N gives inst_valid in cycle N+1 when its slot is at head.
REQ-028 Redirect (highest priority) in cycle N; at the edge ending N:
  - all slots are invalidated and head = fill = tail = 0;
  - drop_cnt <= drop_cnt + (allocated-unfilled slots) - (1 if a discarded response arrives in N);
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
  - a consume in cycle N is not honoured;
  - no request is issued in N (REQ-018).
REQ-029 In cycle N+1 the request address is the redirect target.
REQ-030 drop_cnt width: clog2(DEPTH)+1 bits; it never exceeds DEPTH.
REQ-031 No combinational path from imem_rsp_* to inst_valid, inst or inst_pc.

Reset
REQ-032 Asynchronous assertion (rst = 0) forces:
  - fetch_pc = RESET_PC;
  - head = fill = tail = 0, occupancy = 0, drop_cnt = 0, all filled bits = 0;
  - inst_valid = 0, imem_req_valid = 0 while rst is low.
REQ-033 Deassertion is sampled synchronously; the first request, address RESET_PC, may issue in the first cycle after rst rises.
REQ-034 Reset mid-operation discards all slots and pending drops. Responses to requests issued before reset are the memory's responsibility to suppress.

Verification
REQ-035 Streaming: memory always ready, 1-cycle response latency, inst_ready = 1 -> inst_pc sequence 0x80000000, 0x80000004, 0x80000008...; each inst matches memory; one instruction per cycle in steady state.
REQ-036 Backpressure: inst_ready = 0 for 10 cycles -> exactly DEPTH = 4 requests issued, imem_req_valid = 0 after that. On release, PCs continue from 0x80000010 with none skipped or duplicated.
REQ-037 Redirect with 3 outstanding requests to 0x80001002 -> next imem_req_addr = 0x80001000; the 3 stale responses are dropped; first delivered inst_pc = 0x80001000.
REQ-038 Redirect in the same cycle as a response and a consume -> consume not honoured; the response is counted as one of the dropped ones; drop_cnt ends at outstanding - 1.
REQ-039 PC wrap: XLEN = 64, RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC -> second request address = 0.
REQ-040 Asynchronous reset pulse between clock edges while the buffer is full -> inst_valid and imem_req_valid drop immediately; after release the first request address is RESET_PC.
